// File: rtl/agu_pkg.sv
// Shared types and constants for the 2-D multi-channel address generation unit.
// The channel config struct is sized from the default widths below.
package agu_pkg;

  localparam int DEF_ADDR_WIDTH   = 12;
  localparam int DEF_NUM_CH       = 4;
  localparam int DEF_CNT_WIDTH    = 12;
  localparam int DEF_STRIDE_WIDTH = 4;
  localparam int ADDR_W_FULL      = DEF_ADDR_WIDTH + 2;

  localparam logic [DEF_CNT_WIDTH-1:0] CNT_ZERO = {DEF_CNT_WIDTH{1'b0}};
  localparam logic [DEF_CNT_WIDTH-1:0] CNT_ONE  = {{(DEF_CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W_FULL-1:0]   ADDR_ZERO = {ADDR_W_FULL{1'b0}};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } agu_state_e;

  typedef struct packed {
    logic [ADDR_W_FULL-1:0]      base;
    logic [DEF_STRIDE_WIDTH-1:0] col_stride;
    logic [ADDR_W_FULL-1:0]      row_stride;
    logic [DEF_CNT_WIDTH-1:0]    cols_m1;
    logic [DEF_CNT_WIDTH-1:0]    rows_m1;
    logic                        wrap;
  } agu_cfg_t;

endpackage

// File: rtl/agu_channel.sv
// One address channel: config registers, row/column counters and the IDLE/RUN FSM.
// Per-cycle priority is start > load_en > step.
module agu_channel
  import agu_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   cfg_we,
  input  agu_cfg_t               cfg_in,
  input  logic                   start,
  input  logic                   step,
  input  logic                   load_en,
  input  logic [ADDR_W_FULL-1:0] load_addr,
  output logic [ADDR_W_FULL-1:0] addr,
  output logic                   busy,
  output logic                   last,
  output logic                   done
);

  agu_state_e               state_r, state_s;
  agu_cfg_t                 cfg_r, cfg_s;
  logic [ADDR_W_FULL-1:0]   addr_r, addr_s;
  logic [ADDR_W_FULL-1:0]   row_base_r, row_base_s;
  logic [DEF_CNT_WIDTH-1:0] col_r, col_s;
  logic [DEF_CNT_WIDTH-1:0] row_r, row_s;
  logic                     done_r, done_s;
  logic                     col_last_s;
  logic                     row_last_s;

  assign col_last_s = (col_r == cfg_r.cols_m1);
  assign row_last_s = (row_r == cfg_r.rows_m1);

  // Next-state, address and counter update for one channel.
  always_comb begin
    state_s    = state_r;
    cfg_s      = cfg_r;
    addr_s     = addr_r;
    row_base_s = row_base_r;
    col_s      = col_r;
    row_s      = row_r;
    done_s     = 1'b0;

    if (start) begin
      addr_s     = cfg_r.base;
      row_base_s = cfg_r.base;
      col_s      = CNT_ZERO;
      row_s      = CNT_ZERO;
      state_s    = RUN;
    end else if (load_en) begin
      addr_s = load_addr;
    end else if (step && (state_r == RUN)) begin
      if (!col_last_s) begin
        addr_s = addr_r + {{(ADDR_W_FULL-DEF_STRIDE_WIDTH){1'b0}}, cfg_r.col_stride};
        col_s  = col_r + CNT_ONE;
      end else if (!row_last_s) begin
        row_base_s = row_base_r + cfg_r.row_stride;
        addr_s     = row_base_r + cfg_r.row_stride;
        col_s      = CNT_ZERO;
        row_s      = row_r + CNT_ONE;
      end else begin
        done_s = 1'b1;
        if (cfg_r.wrap) begin
          addr_s     = cfg_r.base;
          row_base_s = cfg_r.base;
          col_s      = CNT_ZERO;
          row_s      = CNT_ZERO;
        end else begin
          state_s = IDLE;
        end
      end
    end else begin
      state_s = state_r;
    end

    // Config may only change while the channel is parked.
    if (cfg_we && (state_r == IDLE) && !start) begin
      cfg_s = cfg_in;
    end else begin
      cfg_s = cfg_r;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= IDLE;
      cfg_r      <= '0;
      addr_r     <= ADDR_ZERO;
      row_base_r <= ADDR_ZERO;
      col_r      <= CNT_ZERO;
      row_r      <= CNT_ZERO;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cfg_r      <= cfg_s;
      addr_r     <= addr_s;
      row_base_r <= row_base_s;
      col_r      <= col_s;
      row_r      <= row_s;
      done_r     <= done_s;
    end
  end

  assign addr = addr_r;
  assign busy = (state_r == RUN);
  assign last = (state_r == RUN) && col_last_s && row_last_s;
  assign done = done_r;

endmodule

// File: rtl/agu_2d_multich.sv
// Multi-channel 2-D address generator: NUM_CH independent channels sharing the
// config/load buses; addresses packed with channel i at [i*(AW+2) +: AW+2].
module agu_2d_multich
  import agu_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int STRIDE_WIDTH = DEF_STRIDE_WIDTH
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [NUM_CH-1:0]                cfg_we,
  input  logic [ADDR_WIDTH+1:0]            cfg_base,
  input  logic [STRIDE_WIDTH-1:0]          cfg_col_stride,
  input  logic [ADDR_WIDTH+1:0]            cfg_row_stride,
  input  logic [CNT_WIDTH-1:0]             cfg_cols_m1,
  input  logic [CNT_WIDTH-1:0]             cfg_rows_m1,
  input  logic                             cfg_wrap,
  input  logic [NUM_CH-1:0]                start,
  input  logic [NUM_CH-1:0]                step,
  input  logic [NUM_CH-1:0]                load_en,
  input  logic [ADDR_WIDTH+1:0]            load_addr,
  output logic [NUM_CH*(ADDR_WIDTH+2)-1:0] addr,
  output logic [NUM_CH-1:0]                busy,
  output logic [NUM_CH-1:0]                last,
  output logic [NUM_CH-1:0]                done
);

  agu_cfg_t cfg_bus_s;

  assign cfg_bus_s.base       = cfg_base;
  assign cfg_bus_s.col_stride = cfg_col_stride;
  assign cfg_bus_s.row_stride = cfg_row_stride;
  assign cfg_bus_s.cols_m1    = cfg_cols_m1;
  assign cfg_bus_s.rows_m1    = cfg_rows_m1;
  assign cfg_bus_s.wrap       = cfg_wrap;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    agu_channel u_ch (
      .clk       (clk),
      .rstn      (rstn),
      .cfg_we    (cfg_we[i]),
      .cfg_in    (cfg_bus_s),
      .start     (start[i]),
      .step      (step[i]),
      .load_en   (load_en[i]),
      .load_addr (load_addr),
      .addr      (addr[i*(ADDR_WIDTH+2) +: (ADDR_WIDTH+2)]),
      .busy      (busy[i]),
      .last      (last[i]),
      .done      (done[i])
    );
  end

endmodule

// File: tb/tb_agu_2d_multich.sv
// Self-checking bench for agu_2d_multich: directed scenarios plus a randomized
// phase, all checked against a pattern-index reference model.
module tb_agu_2d_multich;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  cfg_we, start, step, load_en;
  logic [13:0] cfg_base, cfg_row_stride, load_addr;
  logic [3:0]  cfg_col_stride;
  logic [11:0] cfg_cols_m1, cfg_rows_m1;
  logic        cfg_wrap;
  wire  [55:0] addr;
  wire  [3:0]  busy, last, done;

  int checks = 0;
  int failures = 0;

  // Reference model: position in pattern as a flat element index.
  int          m_base[4], m_cs[4], m_rs[4], m_cm1[4], m_rm1[4];
  bit          m_wrap[4], m_run[4], m_done[4];
  int          m_idx[4];
  logic [13:0] m_addr[4];

  agu_2d_multich dut (
    .clk(clk), .rstn(rstn), .cfg_we(cfg_we), .cfg_base(cfg_base),
    .cfg_col_stride(cfg_col_stride), .cfg_row_stride(cfg_row_stride),
    .cfg_cols_m1(cfg_cols_m1), .cfg_rows_m1(cfg_rows_m1), .cfg_wrap(cfg_wrap),
    .start(start), .step(step), .load_en(load_en), .load_addr(load_addr),
    .addr(addr), .busy(busy), .last(last), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int ch, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s ch%0d observed=0x%0h expected=0x%0h", tag, ch, obs, exp);
    end
  endtask

  function automatic logic [13:0] ch_addr(input int ch);
    logic [55:0] a;
    a = addr;
    return a[ch*14 +: 14];
  endfunction

  function automatic bit m_last(input int i);
    return m_run[i] && (m_idx[i] == (m_cm1[i] + 1) * (m_rm1[i] + 1) - 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_base[i] = 0; m_cs[i] = 0; m_rs[i] = 0; m_cm1[i] = 0; m_rm1[i] = 0;
      m_wrap[i] = 1'b0; m_run[i] = 1'b0; m_done[i] = 1'b0; m_idx[i] = 0;
      m_addr[i] = 14'h0000;
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < 4; i++) begin
      int total, col, row;
      bit was_run;
      was_run = m_run[i];
      total = (m_cm1[i] + 1) * (m_rm1[i] + 1);
      col = m_idx[i] % (m_cm1[i] + 1);
      row = m_idx[i] / (m_cm1[i] + 1);
      m_done[i] = 1'b0;
      if (start[i]) begin
        m_addr[i] = 14'(m_base[i]); m_idx[i] = 0; m_run[i] = 1'b1;
      end else if (load_en[i]) begin
        m_addr[i] = load_addr;
      end else if (step[i] && was_run) begin
        if (m_idx[i] == total - 1) begin
          m_done[i] = 1'b1;
          if (m_wrap[i]) begin
            m_addr[i] = 14'(m_base[i]); m_idx[i] = 0;
          end else begin
            m_run[i] = 1'b0;
          end
        end else if (col != m_cm1[i]) begin
          m_addr[i] = 14'(m_addr[i] + m_cs[i]); m_idx[i]++;
        end else begin
          m_addr[i] = 14'(m_base[i] + (row + 1) * m_rs[i]); m_idx[i]++;
        end
      end
      if (cfg_we[i] && !was_run && !start[i]) begin
        m_base[i] = cfg_base; m_cs[i] = cfg_col_stride; m_rs[i] = cfg_row_stride;
        m_cm1[i] = cfg_cols_m1; m_rm1[i] = cfg_rows_m1; m_wrap[i] = cfg_wrap;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      chk("addr", i, 32'(ch_addr(i)), 32'(m_addr[i]));
      chk("busy", i, 32'(busy[i]), 32'(m_run[i]));
      chk("done", i, 32'(done[i]), 32'(m_done[i]));
      chk("last", i, 32'(last[i]), 32'(m_last(i)));
    end
  endtask

  task automatic idle_inputs();
    cfg_we = 4'h0; start = 4'h0; step = 4'h0; load_en = 4'h0;
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
    check_all();
    idle_inputs();
  endtask

  task automatic configure(input int ch, input logic [13:0] base, input logic [3:0] cs,
                           input logic [13:0] rs, input logic [11:0] cm1,
                           input logic [11:0] rm1, input logic wrap);
    cfg_base = base; cfg_col_stride = cs; cfg_row_stride = rs;
    cfg_cols_m1 = cm1; cfg_rows_m1 = rm1; cfg_wrap = wrap;
    cfg_we = 4'(1 << ch);
    tick();
  endtask

  task automatic do_start(input int ch);
    start = 4'(1 << ch);
    tick();
  endtask

  task automatic do_step(input int ch);
    step = 4'(1 << ch);
    tick();
  endtask

  logic [13:0] t1_seq [8];
  logic [13:0] saved;

  initial begin
    t1_seq = '{14'h010, 14'h011, 14'h012, 14'h013, 14'h110, 14'h111, 14'h112, 14'h113};
    idle_inputs();
    cfg_base = 14'h0; cfg_col_stride = 4'h0; cfg_row_stride = 14'h0;
    cfg_cols_m1 = 12'h0; cfg_rows_m1 = 12'h0; cfg_wrap = 1'b0; load_addr = 14'h0;
    model_reset();
    rstn = 1'b0;
    #12;
    check_all();
    @(negedge clk);
    rstn = 1'b1;

    // Plan 1: 2x4 pattern, no wrap.
    configure(0, 14'h010, 4'd1, 14'h100, 12'd3, 12'd1, 1'b0);
    do_start(0);
    chk("t1_addr0", 0, 32'(ch_addr(0)), 32'(t1_seq[0]));
    for (int k = 1; k < 8; k++) begin
      do_step(0);
      chk("t1_addr", 0, 32'(ch_addr(0)), 32'(t1_seq[k]));
    end
    chk("t1_last", 0, 32'(last[0]), 32'd1);
    do_step(0);
    chk("t1_done", 0, 32'(done[0]), 32'd1);
    chk("t1_busy", 0, 32'(busy[0]), 32'd0);
    chk("t1_hold", 0, 32'(ch_addr(0)), 32'h113);
    do_step(0);
    chk("t1_extra", 0, 32'(ch_addr(0)), 32'h113);
    chk("t1_nodone", 0, 32'(done[0]), 32'd0);

    // Plan 3: address overflow into bank bits.
    configure(0, 14'h3FFE, 4'd2, 14'h0, 12'd0 + 12'd1, 12'd0, 1'b0);
    do_start(0);
    chk("t3_start", 0, 32'(ch_addr(0)), 32'h3FFE);
    do_step(0);
    chk("t3_wrap", 0, 32'(ch_addr(0)), 32'h0000);
    chk("t3_last", 0, 32'(last[0]), 32'd1);
    do_step(0);
    chk("t3_done", 0, 32'(done[0]), 32'd1);

    // Plan 2: same pattern with wrap, two passes.
    configure(0, 14'h010, 4'd1, 14'h100, 12'd3, 12'd1, 1'b1);
    do_start(0);
    for (int k = 1; k < 8; k++) do_step(0);
    do_step(0);
    chk("t2_wrap_addr", 0, 32'(ch_addr(0)), 32'h010);
    chk("t2_busy", 0, 32'(busy[0]), 32'd1);
    chk("t2_done", 0, 32'(done[0]), 32'd1);
    for (int k = 1; k < 8; k++) begin
      do_step(0);
      chk("t2_pass2", 0, 32'(ch_addr(0)), 32'(t1_seq[k]));
    end

    // Plan 6: ch3 activity and a blocked cfg write leave ch0 untouched.
    configure(3, 14'h200, 4'd4, 14'h010, 12'd2, 12'd2, 1'b0);
    do_start(3);
    saved = ch_addr(0);
    for (int k = 0; k < 4; k++) do_step(3);
    chk("t6_indep", 0, 32'(ch_addr(0)), 32'(saved));
    configure(0, 14'h777, 4'd5, 14'h0, 12'd1, 12'd1, 1'b0);
    do_start(0);
    chk("t6_cfg_blocked", 0, 32'(ch_addr(0)), 32'h010);

    // Plan 4: priority start > load > step.
    configure(1, 14'h040, 4'd3, 14'h020, 12'd5, 12'd2, 1'b0);
    do_start(1);
    do_step(1);
    do_step(1);
    start = 4'h2; step = 4'h2; load_en = 4'h2; load_addr = 14'h155;
    tick();
    chk("t4_start_wins", 1, 32'(ch_addr(1)), 32'h040);
    do_step(1);
    chk("t4_col_cleared", 1, 32'(ch_addr(1)), 32'h043);
    load_en = 4'h2; step = 4'h2; load_addr = 14'h2A5;
    tick();
    chk("t4_load", 1, 32'(ch_addr(1)), 32'h2A5);
    do_step(1);
    chk("t4_after_load", 1, 32'(ch_addr(1)), 32'h2A8);

    // Plan 5: async reset mid-pattern on ch2 (row 1, col 2).
    configure(2, 14'h100, 4'd1, 14'h040, 12'd3, 12'd2, 1'b0);
    do_start(2);
    for (int k = 0; k < 6; k++) do_step(2);
    chk("t5_pre", 2, 32'(ch_addr(2)), 32'h142);
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    chk("t5_async_addr", 2, 32'(ch_addr(2)), 32'h0);
    chk("t5_async_busy", 2, 32'(busy), 32'h0);
    chk("t5_async_done", 2, 32'(done), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    do_step(2);
    chk("t5_step_ignored", 2, 32'(busy[2]), 32'd0);
    do_start(2);
    chk("t5_base0", 2, 32'(ch_addr(2)), 32'h0);

    // Randomized traffic on all channels.
    for (int n = 0; n < 600; n++) begin
      cfg_base = 14'($urandom); cfg_col_stride = 4'($urandom);
      cfg_row_stride = 14'($urandom);
      cfg_cols_m1 = 12'($urandom_range(0, 3)); cfg_rows_m1 = 12'($urandom_range(0, 3));
      cfg_wrap = 1'($urandom); load_addr = 14'($urandom);
      for (int i = 0; i < 4; i++) begin
        cfg_we[i]  = ($urandom_range(0, 3) == 0);
        start[i]   = ($urandom_range(0, 15) == 0);
        load_en[i] = ($urandom_range(0, 15) == 0);
        step[i]    = ($urandom_range(0, 1) == 0);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/agu_2d_multich.md
Name: agu_2d_multich

Overview:
Parametrised multi-channel address generation unit. It is the successor to the fixed 4-port increment/stride AGU. Each of NUM_CH independent channels walks a programmable 2-D pattern: a column stride within a row, a row stride between rows, finite row/column counts, and optional auto-wrap. It also supports a one-cycle absolute address load, used for hash/sample jumps. It sits between the controller FSM and the banked RAM address ports; the top 2 address bits remain bank-select bits.

Parameters:
ADDR_WIDTH, 12, word address width; full channel address is ADDR_WIDTH+2 bits (2 bank bits).
NUM_CH, 4, number of independent address channels.
CNT_WIDTH, 12, width of row/column counters and count configs.
STRIDE_WIDTH, 4, width of unsigned column stride.

Ports:
clk  in  1  clock.
rstn  in  1  reset, asynchronous, active-low.
cfg_we  in  NUM_CH  per-channel config write strobe.
cfg_base  in  ADDR_WIDTH+2  start address (shared bus).
cfg_col_stride  in  STRIDE_WIDTH  address increment between elements in a row.
cfg_row_stride  in  ADDR_WIDTH+2  increment from row start to next row start.
cfg_cols_m1  in  CNT_WIDTH  columns per row minus 1.
cfg_rows_m1  in  CNT_WIDTH  rows minus 1.
cfg_wrap  in  1  1 = restart pattern after last element.
start  in  NUM_CH  begin pattern on channel.
step  in  NUM_CH  advance channel by one element.
load_en  in  NUM_CH  force channel address to load_addr.
load_addr  in  ADDR_WIDTH+2  absolute load address (shared).
addr  out  NUM_CH*(ADDR_WIDTH+2)  registered addresses, channel i at bits [i*(AW+2) +: AW+2].
busy  out  NUM_CH  channel in RUN.
last  out  NUM_CH  combinational: busy and current element is final element of pattern.
done  out  NUM_CH  registered 1-cycle pulse on the step that consumes the final element.

Behaviour:
- Reset (async, rstn=0): addr=0, busy=0, done=0, all config registers 0 (base 0, strides 0, cols_m1 0, rows_m1 0, wrap 0), counters 0, state IDLE. Takes effect immediately, including mid-pattern.
- Per-channel state: IDLE, RUN. Channels are fully independent; no shared state except the shared input buses.
- Config: cfg_we[i] captures all cfg_* into channel i's registers only when channel i is IDLE and start[i]=0. cfg_we while in RUN is ignored.
- Priority per channel per cycle: start > load_en > step.
- start[i] (any state): addr<=base, row_base<=base, col=0, row=0, state RUN, busy=1 next cycle. Restart mid-pattern is allowed.
- load_en[i] (RUN or IDLE): addr<=load_addr. Counters, row_base and state are unchanged.
- step[i] in IDLE: ignored.
- step[i] in RUN:
  - col != cols_m1: addr<=addr+col_stride; col++.
  - col == cols_m1, row != rows_m1: row_base<=row_base+row_stride; addr<=row_base+row_stride; col=0; row++.
  - final element (col==cols_m1, row==rows_m1): done pulses next cycle.
    - wrap=1: addr<=base, row_base<=base, counters 0, stay RUN.
    - wrap=0: go IDLE, busy=0, addr holds last value.
- Latency: every address update is visible the cycle after the triggering input. last is valid in the same cycle as the current addr.
- Arithmetic: unsigned, modulo 2^(ADDR_WIDTH+2). Overflow wraps silently into the bank bits (bank crossing is intentional). col_stride=0 is legal: addr repeats while counters advance.
- A single-element pattern (cols_m1=0, rows_m1=0): last=1 immediately after start; first step gives done.

Decomposition:
- Package agu_pkg holds:
  - state typedef (IDLE/RUN)
  - channel config struct (base, col_stride, row_stride, cols_m1, rows_m1, wrap)
  - localparam ADDR_W_FULL = ADDR_WIDTH+2
- Sub-module agu_channel holds one channel's config registers, counters and FSM. The top instantiates it NUM_CH times in a generate loop and packs addr.

Test Plan:
1. ch0 cfg base=0x010, col_stride=1, cols_m1=3, rows_m1=1, row_stride=0x100, wrap=0; start, 8 steps -> addr 0x010,011,012,013,110,111,112,113. last high at 0x113; done pulse after 8th step; busy=0; addr holds 0x113; a 9th step has no effect.
2. Same config with wrap=1 -> after 8th step addr=0x010, busy stays 1, done pulses once; the second pass repeats the same sequence.
3. AW=12, base=0x3FFE, col_stride=2, cols_m1=1, rows_m1=0 -> start gives 0x3FFE; step gives 0x0000 with last=1; next step gives done.
4. Simultaneous start+step+load_en on ch1 -> addr=base with counters cleared. Then load_en+step with load_addr=0x2A5 -> addr=0x2A5 and col unchanged; next step gives 0x2A5+col_stride.
5. rstn dropped mid-pattern on ch2 (row=1, col=2) -> addr=0, busy=0, done=0 asynchronously. After release, a step without start is ignored; a start after reset uses base 0.
6. Channel independence: steps on ch3 only while ch0 is RUN -> ch0 addr and counters are unchanged. cfg_we[0] during RUN -> ch0 config is unchanged, verified at the next start.
